bit_stuffer: RTL

BIT_STUFFER -- requirements
Module: bit_stuffer

---
 rtl/usb_pkg.sv | 14 +
 rtl/bit_stuffer_if.sv | 25 ++
 rtl/bit_stuffer_run.sv | 34 +++
 rtl/bit_stuffer.sv | 87 ++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB transmit-path definitions used by the bit stuffer.
package usb_pkg;

    // Default number of consecutive 1s that forces a stuffed 0.
    localparam int unsigned STUFF_RUN_DEFAULT = 6;

    // Bit stuffer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STUFF  = 2'd2
    } bs_state_t;

endpackage

// File: rtl/bit_stuffer_if.sv
// Bit-serial packet stream into and out of the bit stuffer.
interface bit_stuffer_if;

    logic       in_valid;
    logic       in_bit;
    logic       in_last;
    logic       bs_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic [7:0] stuff_count;

    // Environment side: drives packet bits, observes line bits.
    modport master (
        output in_valid, in_bit, in_last,
        input  bs_ready, out_valid, out_bit, out_last, stuff_count
    );

    // Stuffer side.
    modport slave (
        input  in_valid, in_bit, in_last,
        output bs_ready, out_valid, out_bit, out_last, stuff_count
    );

endinterface

// File: rtl/bit_stuffer_run.sv
// Ones-run counter: tracks consecutive accepted 1s and flags the bit
// that completes a run of STUFF_RUN.
module bs_run_counter
    import usb_pkg::*;
#(
    parameter int unsigned STUFF_RUN = STUFF_RUN_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic accept,
    input  logic data_bit,
    input  logic clr,
    output logic run_hit
);

    localparam logic [2:0] RUN_LIMIT = 3'(STUFF_RUN);

    logic [2:0] run;

    // The accepted bit is a 1 that brings the run to STUFF_RUN.
    assign run_hit = accept && data_bit && (run == RUN_LIMIT - 3'd1);

    // Run register: clear wins over counting; idle cycles hold the run.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples its inputs from the same pre-edge values.
        if (reset || clr) begin
            run <= 3'd0;
        end else if (accept) begin
            run <= data_bit ? run + 3'd1 : 3'd0;
        end
    end

endmodule

// File: rtl/bit_stuffer.sv
// Bit stuffer: inserts a 0 after every STUFF_RUN consecutive 1s of a
// packet and forwards the line bits, registered, toward the NRZI encoder.
module bit_stuffer
    import usb_pkg::*;
#(
    parameter int unsigned STUFF_RUN = STUFF_RUN_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    bit_stuffer_if.slave  bus
);

    bs_state_t state;
    logic      pending_last;
    logic      accept;
    logic      run_hit;
    logic      run_clr;

    // Upstream stalls only while the stuffed bit is being emitted.
    assign bus.bs_ready = (state != STUFF);
    assign accept       = bus.in_valid && bus.bs_ready;

    // Run restarts after each stuffed bit and at every unstuffed packet end.
    assign run_clr = (state == STUFF) || (accept && bus.in_last && !run_hit);

    bs_run_counter #(
        .STUFF_RUN (STUFF_RUN)
    ) u_run (
        .clock    (clock),
        .reset    (reset),
        .accept   (accept),
        .data_bit (bus.in_bit),
        .clr      (run_clr),
        .run_hit  (run_hit)
    );

    // FSM, registered line outputs and per-packet stuff counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            pending_last    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_bit     <= 1'b0;
            bus.out_last    <= 1'b0;
            bus.stuff_count <= 8'd0;
        end else begin
            // NOTE: outputs default to 0 each cycle and are overridden only
            // when a bit is produced, so no path leaves a stale line bit.
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_last  <= 1'b0;
            case (state)
                IDLE, ACTIVE: begin
                    if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.out_bit   <= bus.in_bit;
                        // A last bit that triggers stuffing hands out_last
                        // over to the stuffed 0 that follows it.
                        bus.out_last  <= bus.in_last && !run_hit;
                        if (state == IDLE) begin
                            bus.stuff_count <= 8'd0;
                        end
                        if (run_hit) begin
                            state        <= STUFF;
                            pending_last <= bus.in_last;
                        end else if (bus.in_last) begin
                            state <= IDLE;
                        end else begin
                            state <= ACTIVE;
                        end
                    end
                end
                STUFF: begin
                    bus.out_valid <= 1'b1;
                    bus.out_last  <= pending_last;
                    pending_last  <= 1'b0;
                    if (bus.stuff_count != 8'hFF) begin
                        bus.stuff_count <= bus.stuff_count + 8'd1;
                    end
                    state <= pending_last ? IDLE : ACTIVE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
